// File: rtl/cpu_bus_adapter_if.sv
// Memory-side bus between cpu_bus_adapter and a memory/peripheral.
//   master : the adapter (drives mem_valid, mem_rw, mem_address, mem_wdata)
//   slave  : the memory  (drives mem_ready, mem_rdata)
// Ports (signals):
//   mem_valid    1       beat request
//   mem_ready    1       beat accept / read data valid
//   mem_rw       1       1 = write
//   mem_address  ADDR_W  beat byte address
//   mem_wdata    MEM_W   beat write data
//   mem_rdata    MEM_W   beat read data
interface cpu_bus_adapter_if #(
    parameter int MEM_W  = 32,
    parameter int ADDR_W = 32
) ();
    logic              mem_valid;
    logic              mem_ready;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_address;
    logic [MEM_W-1:0]  mem_wdata;
    logic [MEM_W-1:0]  mem_rdata;

    modport master (
        output mem_valid, mem_rw, mem_address, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_rw, mem_address, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/cpu_bus_adapter.sv
// cpu_bus_adapter: bridges the core's single-word data port to a handshaked
// memory bus of width MEM_W (8/16/32). Each 32-bit access is split into
// 32/MEM_W little-endian beats; the core is stalled until the access ends and
// read data is reassembled into cpu_data_in.
//
// Optional feature: define CPUBUS_TIMEOUT_EN to abort a beat that waits
// TIMEOUT cycles without mem_ready (cpu_err=1, read data all ones).
// Without it a beat waits forever and cpu_err is tied low.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   cpu_req        access request (level, held until cpu_done)
//   cpu_rw         1 = write
//   cpu_address    byte address, bits [1:0] ignored
//   cpu_data_out   write data from core
//   cpu_data_in    read data to core, valid with cpu_done, held otherwise
//   cpu_stall      core must hold
//   cpu_done       one-cycle completion pulse
//   cpu_err        bus error, qualified by cpu_done
//   bus            memory bus (cpu_bus_adapter_if.master)
module cpu_bus_adapter #(
    parameter int MEM_W   = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [31:0]       cpu_address,
    input  logic [31:0]       cpu_data_out,
    output logic [31:0]       cpu_data_in,
    output logic              cpu_stall,
    output logic              cpu_done,
    output logic              cpu_err,
    cpu_bus_adapter_if.master bus
);
    localparam int BEATS  = 32 / MEM_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BYTES  = MEM_W / 8;

    if (!(MEM_W == 8 || MEM_W == 16 || MEM_W == 32)) begin : g_bad_mem_w
        $error("cpu_bus_adapter: MEM_W must be 8, 16 or 32 (got %0d)", MEM_W);
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("cpu_bus_adapter: TIMEOUT must be >= 1 (got %0d)", TIMEOUT);
    end

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        DONE
    } state_t;

    state_t            state;
    logic [BEAT_W-1:0] beat;
    logic              rw_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rbuf;
    logic [31:0]       rd_word;
    logic [MEM_W-1:0]  next_wdata;
    logic              xfer;
    logic              last_beat;
    int unsigned       cur_lane;
    int unsigned       next_lane;

    // Word-aligned addressing: the low address bits never reach the bus.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, cpu_address[1:0]};

    always_comb begin
        cur_lane   = 32'(beat);
        next_lane  = (cur_lane + 1) % BEATS;
        // Final word includes the beat being accepted this cycle, so
        // cpu_data_in is already correct in the DONE cycle.
        rd_word    = rbuf;
        rd_word[cur_lane*MEM_W +: MEM_W] = bus.mem_rdata;
        next_wdata = wdata_q[next_lane*MEM_W +: MEM_W];
        xfer       = (state == BUS) && bus.mem_valid && bus.mem_ready;
        last_beat  = (cur_lane == BEATS - 1);
    end

    assign cpu_stall = !reset && ((state == IDLE && cpu_req) || state == BUS);

`ifdef CPUBUS_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_hit;
    // A ready in the TIMEOUT-th cycle wins: xfer is tested before this.
    assign timeout_hit = (state == BUS) && !bus.mem_ready &&
                         (wait_cnt == WAIT_W'(TIMEOUT - 1));
`else
    assign cpu_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            beat            <= '0;
            rw_q            <= 1'b0;
            wdata_q         <= '0;
            rbuf            <= '0;
            cpu_data_in     <= '0;
            cpu_done        <= 1'b0;
            bus.mem_valid   <= 1'b0;
            bus.mem_rw      <= 1'b0;
            bus.mem_address <= '0;
            bus.mem_wdata   <= '0;
`ifdef CPUBUS_TIMEOUT_EN
            wait_cnt        <= '0;
            cpu_err         <= 1'b0;
`endif
        end else begin
            cpu_done <= 1'b0;
`ifdef CPUBUS_TIMEOUT_EN
            cpu_err  <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (cpu_req) begin
                        state           <= BUS;
                        beat            <= '0;
                        rw_q            <= cpu_rw;
                        wdata_q         <= cpu_data_out;
                        bus.mem_valid   <= 1'b1;
                        bus.mem_rw      <= cpu_rw;
                        bus.mem_address <= ADDR_W'({cpu_address[31:2], 2'b00});
                        bus.mem_wdata   <= cpu_data_out[MEM_W-1:0];
`ifdef CPUBUS_TIMEOUT_EN
                        wait_cnt        <= '0;
`endif
                    end
                end
                BUS: begin
                    if (xfer) begin
                        if (!rw_q) begin
                            rbuf[cur_lane*MEM_W +: MEM_W] <= bus.mem_rdata;
                        end
`ifdef CPUBUS_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                        if (last_beat) begin
                            state         <= DONE;
                            bus.mem_valid <= 1'b0;
                            cpu_done      <= 1'b1;
                            if (!rw_q) begin
                                cpu_data_in <= rd_word;
                            end
                        end else begin
                            beat            <= beat + 1'b1;
                            bus.mem_address <= bus.mem_address + ADDR_W'(BYTES);
                            bus.mem_wdata   <= next_wdata;
                        end
                    end
`ifdef CPUBUS_TIMEOUT_EN
                    else if (timeout_hit) begin
                        state         <= DONE;
                        bus.mem_valid <= 1'b0;
                        cpu_done      <= 1'b1;
                        cpu_err       <= 1'b1;
                        wait_cnt      <= '0;
                        if (!rw_q) begin
                            cpu_data_in <= '1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/cpu_bus_adapter.md
# cpu_bus_adapter

Parametrised memory-side bus adapter between the CPU core's single-word data port and a handshaked memory bus of configurable width. Splits each 32-bit CPU access into 32/MEM_W little-endian beats, inserts wait states by stalling the core, and reassembles read data. Sits between `cpu` and memory, replacing the CPU's fixed single-cycle data/address/rw connection.

## Interface
Parameters:
- MEM_W, 32, memory data width; legal values 8, 16, 32; any other value is a simulation `$error`.
- ADDR_W, 32, memory address width.
- TIMEOUT, 16, wait cycles per beat before abort; used only with CPUBUS_TIMEOUT_EN; must be ≥1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  access request; level, held by the core until cpu_done
- cpu_rw  in  1  1 = write
- cpu_address  in  32  byte address; bits [1:0] ignored
- cpu_data_out  in  32  write data from core
- cpu_data_in  out  32  read data to core; valid when cpu_done
- cpu_stall  out  1  core must hold
- cpu_done  out  1  one-cycle completion pulse
- cpu_err  out  1  bus error, qualified by cpu_done
- mem_valid  out  1  beat request
- mem_ready  in  1  beat accept / read data valid
- mem_rw  out  1  1 = write
- mem_address  out  ADDR_W  beat byte address
- mem_wdata  out  MEM_W  beat write data
- mem_rdata  in  MEM_W  beat read data

## Operation
- BEATS = 32/MEM_W; beat counter width clog2(BEATS), minimum 1.
- States: IDLE, BUS, DONE.
- IDLE: cpu_req=1 latches rw, address, write data; beat=0; -> BUS.
- BUS: mem_valid=1; mem_address = {cpu_address[31:2],2'b00} + beat·(MEM_W/8), truncated to ADDR_W; mem_wdata = cpu_data_out[beat·MEM_W +: MEM_W]; mem_rw = latched rw.
- Transfer when mem_valid && mem_ready. On reads, mem_rdata is captured into lane beat of the assembly buffer. On a non-last beat, beat increments and the bus stays in BUS; mem_valid stays high (back-to-back beats). On the last beat -> DONE.
- While mem_ready=0, mem_address, mem_wdata, mem_rw and mem_valid are held stable.
- DONE: cpu_done=1 and mem_valid=0; on reads, cpu_data_in is loaded with the assembled word. Always -> IDLE. cpu_req is ignored in DONE. A req still high in the following IDLE cycle starts a new access.
- cpu_data_in holds its value until the next read completes; writes leave it unchanged.
- cpu_stall = (IDLE && cpu_req) || BUS. It is 0 in DONE and forced to 0 while reset=1.
- Reset, including mid-beat: next state IDLE. mem_valid, mem_rw, mem_address, mem_wdata, cpu_data_in, cpu_done, cpu_err and the beat counter are all 0. No cpu_done is issued for the aborted access.

## Timing
- Request seen in IDLE at cycle 0. First beat is valid at cycle 1.
- Zero-wait-state access completes with cpu_done at cycle BEATS+1. MEM_W=32 gives 2 cycles; MEM_W=8 gives 5 cycles.
- Each cycle mem_ready is low adds one cycle.
- Back-to-back CPU accesses have a minimum spacing of BEATS+2 cycles (the DONE and IDLE cycles are overhead).

## Configuration
- CPUBUS_TIMEOUT_EN defined:
  - A per-beat counter counts BUS cycles with mem_valid high and no transfer.
  - The counter clears on each transfer.
  - If a beat has been valid for TIMEOUT cycles without mem_ready, the access aborts: mem_valid=0 next cycle, state -> DONE with cpu_done=1 and cpu_err=1.
  - On a read abort, cpu_data_in = 32'hFFFF_FFFF.
  - mem_ready arriving in the TIMEOUT-th cycle completes the beat normally.
- Undefined: no counter; a beat waits indefinitely; cpu_err is tied 0.

## Test plan
- MEM_W=32, mem_ready tied 1, read 0x100, mem_rdata=0xDEADBEEF -> mem_valid at cycle 1 with address 0x100; cpu_done at cycle 2 with cpu_data_in=0xDEADBEEF; cpu_stall high at cycles 0–1 only.
- MEM_W=8, write 0x11223344 to 0x203 -> beats at addresses 0x200, 0x201, 0x202, 0x203 carrying 0x44, 0x33, 0x22, 0x11; cpu_done at cycle 5.
- MEM_W=16, read 0x40, mem_ready low until cycle 4, rdata 0xBEEF then 0xCAFE -> beat 0 is held stable at cycles 1–4; beat 1 (address 0x42) transfers at cycle 5; cpu_done at cycle 6 with cpu_data_in=0xCAFEBEEF.
- Reset pulsed at cycle 2 of an 8-bit read -> at cycle 3 mem_valid=0 and all outputs are 0; no cpu_done. A new req at cycle 4 gives its first beat at cycle 5.
- CPUBUS_TIMEOUT_EN, TIMEOUT=4, MEM_W=32, read with mem_ready never high -> mem_valid at cycles 1–4; cpu_done=cpu_err=1 at cycle 5 with cpu_data_in=0xFFFFFFFF. Without the macro, cpu_stall stays high indefinitely.
- cpu_req held high across two accesses -> the DONE-cycle req is ignored; the second access's first beat comes 2 cycles after the first access's DONE cycle.
